// File: rtl/ula_seq_param_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ULA.
// Latency: none (definitions only).
// Backpressure: not applicable.
package ula_seq_param_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOTA = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_LSL  = 3'b110;
  localparam logic [2:0] OP_LSR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/ula_seq_comb.sv
// Combinational logic/arithmetic unit for opcodes 000-101 (shifts handled by the caller).
// Latency: purely combinational.
// Backpressure: none; the caller samples the outputs when it needs them.
module ula_seq_comb #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);
  import ula_seq_param_pkg::*;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Extended by one bit so the top bit is carry (ADD) or borrow (SUB).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Opcode decode; shift opcodes fall through to zero since they never reach here.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOTA: result = ~a;
      OP_NAND: result = ~(a & b);
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ula_seq_param.sv
// Sequential ULA: registered logic/arith ops plus iterative one-bit-per-clock shifts.
// Latency: 1 cycle for logic/arith, 1+min(B,SHIFT_MAX) cycles for LSL/LSR.
// Backpressure: start_in is dropped (not queued) while busy or in the done cycle.
module ula_seq_param #(
  parameter int WIDTH     = 8,
  parameter int SHIFT_MAX = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op_sel,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] resultado_out,
  output logic             carry_out,
  output logic             zero_out,
  output logic             neg_out,
  output logic             ovf_out
);
  import ula_seq_param_pkg::*;

  localparam int CW = $clog2(SHIFT_MAX + 1);

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_init;
  logic             carry_work;
  logic             accept;
  logic             exec_fin;
  logic             shift_fin;
  logic             shift_step;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;

  ula_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res),
    .carry  (alu_carry),
    .ovf    (alu_ovf)
  );

  // Saturate the requested shift amount to SHIFT_MAX.
  always_comb begin
    cnt_init = CW'(SHIFT_MAX);
    if (b_in <= WIDTH'(SHIFT_MAX)) begin
      cnt_init = CW'(b_in);
    end
  end

  // Next-state and control strobes; start is refused in the done cycle.
  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    exec_fin   = 1'b0;
    shift_fin  = 1'b0;
    shift_step = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_in && !done_out) begin
          accept  = 1'b1;
          state_d = (op_sel == OP_LSL || op_sel == OP_LSR) ? S_SHIFT : S_EXEC;
        end
      end
      S_EXEC: begin
        exec_fin = 1'b1;
        state_d  = S_IDLE;
      end
      S_SHIFT: begin
        if (cnt == '0) begin
          shift_fin = 1'b1;
          state_d   = S_IDLE;
        end else begin
          shift_step = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Operand latches and the iterative shifter working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_AND;
      work       <= '0;
      cnt        <= '0;
      carry_work <= 1'b0;
    end else if (accept) begin
      a_q        <= a_in;
      b_q        <= b_in;
      op_q       <= op_sel;
      work       <= a_in;
      cnt        <= cnt_init;
      carry_work <= 1'b0;
    end else if (shift_step) begin
      if (op_q == OP_LSL) begin
        carry_work <= work[WIDTH-1];
        work       <= {work[WIDTH-2:0], 1'b0};
      end else begin
        carry_work <= work[0];
        work       <= {1'b0, work[WIDTH-1:1]};
      end
      cnt <= cnt - CW'(1);
    end
  end

  // Result/flag registers; they hold between done pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_out      <= 1'b0;
      resultado_out <= '0;
      carry_out     <= 1'b0;
      zero_out      <= 1'b0;
      neg_out       <= 1'b0;
      ovf_out       <= 1'b0;
    end else begin
      done_out <= exec_fin | shift_fin;
      if (exec_fin) begin
        resultado_out <= alu_res;
        carry_out     <= alu_carry;
        zero_out      <= (alu_res == '0);
        neg_out       <= alu_res[WIDTH-1];
        ovf_out       <= alu_ovf;
      end else if (shift_fin) begin
        resultado_out <= work;
        carry_out     <= carry_work;
        zero_out      <= (work == '0);
        neg_out       <= work[WIDTH-1];
        ovf_out       <= 1'b0;
      end
    end
  end

  assign busy_out = (state != S_IDLE);

endmodule
